// File: rtl/mem_sequencer_pkg.sv
// Shared types and constants for the SLC-3 memory sequencer: FSM state encoding,
// memory-mapped I/O address and default widths.
package slc3_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_DONE
  } mem_state_t;

  localparam logic [15:0] IO_ADDR      = 16'hFFFF;
  localparam int          DEF_ADDR_W   = 20;
  localparam int          DEF_RD_WAIT  = 1;
  localparam int          DEF_WR_PULSE = 1;
  localparam int          CNT_W        = 8;

endpackage

// File: rtl/mem_sequencer_if.sv
// CPU-side strobes plus SRAM pins of the memory sequencer; slave = sequencer,
// master = CPU/board side that drives requests and returns SRAM read data.
interface mem_sequencer_if #(
  parameter int ADDR_W = slc3_mem_pkg::DEF_ADDR_W
);

  logic              Mem_OE;
  logic              Mem_WE;
  logic [15:0]       MAR;
  logic [15:0]       MDR;
  logic [15:0]       Data_to_CPU;
  logic              Mem_Ready;
  logic [15:0]       Data_from_SRAM;
  logic [15:0]       Data_to_SRAM;
  logic              Data_drive;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic              SRAM_CE_N;
  logic              SRAM_OE_N;
  logic              SRAM_WE_N;
  logic              SRAM_UB_N;
  logic              SRAM_LB_N;

  modport master (
    output Mem_OE, Mem_WE, MAR, MDR, Data_from_SRAM,
    input  Data_to_CPU, Mem_Ready, Data_to_SRAM, Data_drive, SRAM_ADDR,
           SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N
  );

  modport slave (
    input  Mem_OE, Mem_WE, MAR, MDR, Data_from_SRAM,
    output Data_to_CPU, Mem_Ready, Data_to_SRAM, Data_drive, SRAM_ADDR,
           SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N
  );

endinterface

// File: rtl/mem_sequencer_wait_counter.sv
// Loadable down-counter timing read waits and write pulses; tc is high while the
// count is zero, i.e. in the final cycle of the timed phase. Load wins over decrement.
module mem_wait_counter
  import slc3_mem_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/mem_sequencer.sv
// SRAM cycle sequencer: read completes RD_WAIT cycles after launch, write takes WR_PULSE+2;
// one Mem_Ready pulse per strobe assertion. IO_PORT_EN maps 0xFFFF to Switches/HEX_Data.
module mem_sequencer
  import slc3_mem_pkg::*;
#(
  parameter int RD_WAIT  = DEF_RD_WAIT,
  parameter int WR_PULSE = DEF_WR_PULSE,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [15:0]   Switches,
  output logic [15:0]   HEX_Data,
  mem_sequencer_if.slave bus
);

  mem_state_t       state;
  logic [15:0]      addr_q;
  logic [15:0]      data_q;
  logic [15:0]      rd_q;
  logic [15:0]      cur_addr;
  logic [15:0]      rd_src;
  logic             launch_rd;
  logic             in_rd;
  logic             in_wr;
  logic             io_hit;
  logic             tc;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;

  // A read starts driving the SRAM in the IDLE cycle it is seen, before the address is latched.
  assign launch_rd = Reset && (state == S_IDLE) && bus.Mem_OE && !bus.Mem_WE;
  assign cur_addr  = launch_rd ? bus.MAR : addr_q;

`ifdef IO_PORT_EN
  logic [15:0] hex_q;

  assign io_hit = (cur_addr == IO_ADDR);
  assign rd_src = io_hit ? Switches : bus.Data_from_SRAM;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      hex_q <= '0;
    end else if ((state == S_WR_SETUP) && io_hit) begin
      hex_q <= data_q;
    end
  end

  assign HEX_Data = hex_q;
`else
  logic unused_switches;

  assign io_hit          = 1'b0;
  assign rd_src          = bus.Data_from_SRAM;
  assign HEX_Data        = '0;
  assign unused_switches = ^Switches;
`endif

  assign cnt_load = launch_rd || (state == S_WR_SETUP);
  assign cnt_val  = launch_rd ? CNT_W'(RD_WAIT - 1) : CNT_W'(WR_PULSE - 1);

  mem_wait_counter u_wait (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tc       (tc)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state  <= S_IDLE;
      addr_q <= '0;
      data_q <= '0;
      rd_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.Mem_WE) begin
            addr_q <= bus.MAR;
            data_q <= bus.MDR;
            state  <= S_WR_SETUP;
          end else if (bus.Mem_OE) begin
            addr_q <= bus.MAR;
            state  <= S_RD;
          end
        end
        S_RD: begin
          if (tc) begin
            rd_q  <= rd_src;
            state <= S_DONE;
          end
        end
        S_WR_SETUP: state <= S_WR_PULSE;
        S_WR_PULSE: if (tc) state <= S_WR_HOLD;
        S_WR_HOLD:  state <= S_DONE;
        // Holding here until both strobes drop keeps a long strobe from re-triggering.
        S_DONE:     if (!bus.Mem_OE && !bus.Mem_WE) state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end

  assign in_rd = launch_rd || (state == S_RD);
  assign in_wr = (state == S_WR_SETUP) || (state == S_WR_PULSE) || (state == S_WR_HOLD);

  assign bus.SRAM_CE_N    = !((in_rd || in_wr) && !io_hit);
  assign bus.SRAM_OE_N    = !in_rd;
  assign bus.SRAM_WE_N    = (state != S_WR_PULSE);
  assign bus.SRAM_UB_N    = !(in_rd || in_wr);
  assign bus.SRAM_LB_N    = !(in_rd || in_wr);
  assign bus.Data_drive   = in_wr;
  assign bus.Data_to_SRAM = data_q;
  assign bus.SRAM_ADDR    = ADDR_W'(cur_addr);
  assign bus.Mem_Ready    = ((state == S_RD) && tc) || (state == S_WR_HOLD);
  assign bus.Data_to_CPU  = in_rd ? rd_src : rd_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Bench for mem_sequencer: default-timing and slow-timing instances, each with an SRAM model.
module tb_mem_sequencer;
  import slc3_mem_pkg::*;

  localparam int RW1 = 1, WP1 = 1, RW2 = 3, WP2 = 2;
`ifdef IO_PORT_EN
  localparam logic [15:0] IO_RD_EXP = 16'h5A5A;
`else
  localparam logic [15:0] IO_RD_EXP = 16'h00A5;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, sel = 1'b0, oe = 1'b0, we = 1'b0, preload = 1'b1;
  logic [15:0] mar = '0, mdr = '0, sw = '0;
  logic [15:0] hex1, hex2;
  int          checks = 0, errors = 0;

  mem_sequencer_if #(.ADDR_W(20)) bus1 ();
  mem_sequencer_if #(.ADDR_W(20)) bus2 ();

  mem_sequencer #(.RD_WAIT(RW1), .WR_PULSE(WP1), .ADDR_W(20)) dut1 (
    .Clk(clk), .Reset(rst_n), .Switches(sw), .HEX_Data(hex1), .bus(bus1));
  mem_sequencer #(.RD_WAIT(RW2), .WR_PULSE(WP2), .ADDR_W(20)) dut2 (
    .Clk(clk), .Reset(rst_n), .Switches(sw), .HEX_Data(hex2), .bus(bus2));

  assign bus1.Mem_OE = oe & ~sel;
  assign bus1.Mem_WE = we & ~sel;
  assign bus1.MAR    = mar;
  assign bus1.MDR    = mdr;
  assign bus2.Mem_OE = oe & sel;
  assign bus2.Mem_WE = we & sel;
  assign bus2.MAR    = mar;
  assign bus2.MDR    = mdr;

  // Asynchronous-read SRAM models; a write lands on any edge with WE_N low and CE_N low.
  logic [15:0] mem1 [0:65535];
  logic [15:0] mem2 [0:255];
  assign bus1.Data_from_SRAM = (!bus1.SRAM_CE_N && !bus1.SRAM_OE_N) ? mem1[bus1.SRAM_ADDR[15:0]] : 16'hFFFF;
  assign bus2.Data_from_SRAM = (!bus2.SRAM_CE_N && !bus2.SRAM_OE_N) ? mem2[bus2.SRAM_ADDR[7:0]] : 16'hFFFF;
  always @(posedge clk) begin
    if (preload) mem1[16'h3000] <= 16'h1234;
    else if (!bus1.SRAM_CE_N && !bus1.SRAM_WE_N && bus1.Data_drive) mem1[bus1.SRAM_ADDR[15:0]] <= bus1.Data_to_SRAM;
    if (!bus2.SRAM_CE_N && !bus2.SRAM_WE_N && bus2.Data_drive) mem2[bus2.SRAM_ADDR[7:0]] <= bus2.Data_to_SRAM;
  end

  logic        s_ready, s_oe_n, s_ce_n, s_we_n, s_ub_n, s_lb_n, s_drive;
  logic [15:0] s_dtc, s_hex;
  logic [3:0]  s_hi;
  assign s_ready = sel ? bus2.Mem_Ready   : bus1.Mem_Ready;
  assign s_oe_n  = sel ? bus2.SRAM_OE_N   : bus1.SRAM_OE_N;
  assign s_ce_n  = sel ? bus2.SRAM_CE_N   : bus1.SRAM_CE_N;
  assign s_we_n  = sel ? bus2.SRAM_WE_N   : bus1.SRAM_WE_N;
  assign s_ub_n  = sel ? bus2.SRAM_UB_N   : bus1.SRAM_UB_N;
  assign s_lb_n  = sel ? bus2.SRAM_LB_N   : bus1.SRAM_LB_N;
  assign s_drive = sel ? bus2.Data_drive  : bus1.Data_drive;
  assign s_dtc   = sel ? bus2.Data_to_CPU : bus1.Data_to_CPU;
  assign s_hex   = sel ? hex2 : hex1;
  assign s_hi    = sel ? bus2.SRAM_ADDR[19:16] : bus1.SRAM_ADDR[19:16];

  // Reference model of the default instance: word memory plus the I/O register.
  logic [15:0] ref_mem [int];
  logic [15:0] ref_hex = '0;

  function automatic logic [15:0] model_read(input logic [15:0] a);
`ifdef IO_PORT_EN
    if (a == IO_ADDR) return sw;
`endif
    return ref_mem[int'(a)];
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic access(input bit s, input bit w, input bit r, input logic [15:0] a,
                        input logic [15:0] d, input int hold, input logic [15:0] exp_rd);
    int k = 0, rdy_k = -1, rdy_n = 0, we_lo = 0, ce_lo = 0, oe_lo = 0, lane_lo = 0;
    int contend = 0, hi_bad = 0, exp_rdy;
    bit oe_lo0 = 1'b0, is_io = 1'b0;
    logic [15:0] d0 = '0, drdy = '0, ddone = '0;
`ifdef IO_PORT_EN
    is_io = (a == IO_ADDR);
`endif
    exp_rdy = s ? (w ? WP2 + 2 : RW2) : (w ? WP1 + 2 : RW1);
    sel = s; we = w; oe = r; mar = a; mdr = d;
    while (1) begin
      @(negedge clk);
      if (s_ready) begin rdy_n++; if (rdy_k < 0) begin rdy_k = k; drdy = s_dtc; end end
      if (!s_we_n) we_lo++;
      if (!s_ce_n) ce_lo++;
      if (!s_oe_n) oe_lo++;
      if (!s_ub_n && !s_lb_n) lane_lo++;
      if (!s_oe_n && s_drive) contend++;
      if (s_hi != 4'h0) hi_bad++;
      if (k == 0) begin oe_lo0 = !s_oe_n; d0 = s_dtc; end
      if (rdy_k >= 0 && k == rdy_k + 1) ddone = s_dtc;
      @(posedge clk); #1;
      k++;
      if (k == 1) begin mar = ~a; mdr = ~d; end
      if (k == hold) begin we = 1'b0; oe = 1'b0; end
      if ((rdy_k >= 0 && k >= hold + 1 && k >= rdy_k + 2) || k >= 60) break;
    end
    we = 1'b0; oe = 1'b0;
    chk("ready_count", rdy_n, 1);
    chk("ready_latency", rdy_k, exp_rdy);
    chk("no_contention", contend, 0);
    chk("addr_upper_zero", hi_bad, 0);
    chk("ce_asserted", int'(ce_lo != 0), int'(!is_io));
    if (w) begin
      chk("we_low_cycles", we_lo, s ? WP2 : WP1);
      chk("oe_during_write", oe_lo, 0);
      chk("lanes_write", lane_lo, exp_rdy);
      if (!s) begin
        if (is_io) ref_hex = d;
        else ref_mem[int'(a)] = d;
      end
    end else begin
      chk("oe_at_launch", int'(oe_lo0), 1);
      chk("oe_cycles", oe_lo, exp_rdy + 1);
      chk("we_during_read", we_lo, 0);
      chk("lanes_read", lane_lo, exp_rdy + 1);
      chk("rdata_launch", int'(d0), int'(exp_rd));
      chk("rdata_ready", int'(drdy), int'(exp_rd));
      chk("rdata_held", int'(ddone), int'(exp_rd));
    end
    chk("hex_data", int'(s_hex), s ? 0 : int'(ref_hex));
  endtask

  typedef struct {
    bit          s;
    bit          w;
    bit          r;
    logic [15:0] a;
    logic [15:0] d;
    int          hold;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t tbl [13];
  logic [15:0] pick [4];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 16'h3000, 16'h0000, 2, 16'h1234};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 16'h0042, 16'hBEEF, 3, 16'h0000};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 16'h0042, 16'h0000, 2, 16'hBEEF};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 16'h0100, 16'h5555, 3, 16'h0000};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 16'h0100, 16'h0000, 5, 16'h5555};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h00A5, 3, 16'h0000};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 2, IO_RD_EXP};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 16'h3000, 16'h0F0F, 1, 16'h0000};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 16'h3000, 16'h0000, 1, 16'h0F0F};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 16'h0010, 16'h1111, 4, 16'h0000};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 3, 16'h1111};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 16'h0020, 16'h2222, 1, 16'h0000};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 16'h0020, 16'h0000, 6, 16'h2222};
    pick[0] = 16'h0042; pick[1] = 16'h0100; pick[2] = 16'h3000; pick[3] = 16'hFFFF;
    ref_mem[int'(16'h3000)] = 16'h1234;

    // Reset held two edges; a read request during reset must not reach the pins.
    @(posedge clk); #1;
    preload = 1'b0; oe = 1'b1;
    @(negedge clk);
    chk("rst_ce_n", int'(bus1.SRAM_CE_N), 1);
    chk("rst_oe_n", int'(bus1.SRAM_OE_N), 1);
    chk("rst_we_n", int'(bus1.SRAM_WE_N), 1);
    chk("rst_lanes", int'({bus1.SRAM_UB_N, bus1.SRAM_LB_N}), 3);
    chk("rst_drive", int'(bus1.Data_drive), 0);
    chk("rst_ready", int'(bus1.Mem_Ready), 0);
    chk("rst_hex", int'(hex1), 0);
    chk("rst_addr", int'(bus1.SRAM_ADDR), 0);
    chk("rst_dtc", int'(bus1.Data_to_CPU), 0);
    chk("rst_slow_ce_n", int'(bus2.SRAM_CE_N), 1);
    @(posedge clk); #1;
    oe = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    sw = 16'h5A5A;

    for (int i = 0; i < 13; i++)
      access(tbl[i].s, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].hold, tbl[i].exp_rd);

    // Reset landing in the middle of the write pulse.
    sel = 1'b0; mar = 16'h7777; mdr = 16'hCAFE; we = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pulse_we_n", int'(bus1.SRAM_WE_N), 0);
    chk("pulse_drive", int'(bus1.Data_drive), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    we = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("midrst_we_n", int'(bus1.SRAM_WE_N), 1);
      chk("midrst_drive", int'(bus1.Data_drive), 0);
      chk("midrst_ce_n", int'(bus1.SRAM_CE_N), 1);
      chk("midrst_ready", int'(bus1.Mem_Ready), 0);
      chk("midrst_hex", int'(hex1), 0);
      if (c == 1) rst_n = 1'b1;
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    ref_hex = '0;
    access(1'b0, 1'b0, 1'b1, 16'h0042, 16'h0000, 2, model_read(16'h0042));

    for (int n = 0; n < 40; n++) begin
      logic [15:0] a, d;
      int op, hold;
      a = pick[$urandom_range(0, 3)];
      d = 16'($urandom);
      op = int'($urandom_range(0, 2));
      hold = int'($urandom_range(1, 6));
      if ($urandom_range(0, 3) == 0) sw = 16'($urandom);
      if (op == 0) access(1'b0, 1'b0, 1'b1, a, 16'h0000, hold, model_read(a));
      else access(1'b0, 1'b1, op == 2, a, d, hold, 16'h0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
